// File: rtl/cache_pkg.sv
// rtl/cache_pkg.sv - shared cache geometry, line layout and refill FSM states
package cache_pkg;

    localparam int ADDR_W  = 16;
    localparam int DATA_W  = 32;
    localparam int TAG_W   = 4;
    localparam int INDEX_W = 8;
    localparam int WORDS   = 4;
    localparam int WSEL_W  = 2;
    localparam int LINE_W  = 1 + TAG_W + WORDS * DATA_W;

    // data[WORDS-1] is word 0 so the line reads {valid, tag, w0, w1, w2, w3} MSB first
    typedef struct packed {
        logic                          valid;
        logic [TAG_W-1:0]              tag;
        logic [WORDS-1:0][DATA_W-1:0]  data;
    } cache_line_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        REQ   = 2'd1,
        WAIT  = 2'd2,
        WRITE = 2'd3
    } fill_state_e;

endpackage

// File: rtl/cache_line_filler.sv
// rtl/cache_line_filler.sv - cache refill engine: fetches a 4-word block and writes one line
// Optional CRITICAL_WORD_FIRST_EN: fetch starts at the missed word and adds crit_valid/crit_data.
module cache_line_filler #(
    parameter int ADDR_W      = 16,
    parameter int DATA_W      = 32,
    parameter int RSP_TIMEOUT = 255
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       miss_valid,
    output logic                       miss_ready,
    input  logic [ADDR_W-1:0]          miss_addr,
    output logic                       mem_req_valid,
    input  logic                       mem_req_ready,
    output logic [ADDR_W-1:0]          mem_req_addr,
    input  logic                       mem_rsp_valid,
    input  logic [DATA_W-1:0]          mem_rsp_data,
    output logic                       line_we,
    output logic [7:0]                 line_index,
    output logic [cache_pkg::LINE_W-1:0] line_data,
    output logic                       fill_done,
    output logic                       fill_err,
    output logic                       busy
`ifdef CRITICAL_WORD_FIRST_EN
    ,
    output logic                       crit_valid,
    output logic [DATA_W-1:0]          crit_data
`endif
);
    import cache_pkg::*;

    localparam int TIMER_W = $clog2(RSP_TIMEOUT + 1);

    fill_state_e          state_q, state_d;
    logic [TAG_W-1:0]     tag_q, tag_d;
    logic [INDEX_W-1:0]   index_q, index_d;
    logic [WSEL_W-1:0]    base_q, base_d;
    logic [WSEL_W-1:0]    word_cnt_q, word_cnt_d;
    logic [TIMER_W-1:0]   timer_q, timer_d;
    logic [DATA_W-1:0]    wbuf_q [WORDS];
    logic [DATA_W-1:0]    wbuf_d [WORDS];

    logic [WSEL_W-1:0]    cur_word;
    cache_line_t          line;
    logic                 unused_addr_bits;

    assign unused_addr_bits = ^miss_addr[3:0];
    assign cur_word         = base_q + word_cnt_q;
    assign busy             = (state_q != IDLE);

    always_comb begin
        line.valid = 1'b1;
        line.tag   = tag_q;
        line.data  = {wbuf_q[0], wbuf_q[1], wbuf_q[2], wbuf_q[3]};
    end

    always_comb begin
        state_d       = state_q;
        tag_d         = tag_q;
        index_d       = index_q;
        base_d        = base_q;
        word_cnt_d    = word_cnt_q;
        timer_d       = timer_q;
        wbuf_d        = wbuf_q;
        miss_ready    = 1'b0;
        mem_req_valid = 1'b0;
        mem_req_addr  = '0;
        line_we       = 1'b0;
        line_index    = '0;
        line_data     = '0;
        fill_done     = 1'b0;
        fill_err      = 1'b0;
`ifdef CRITICAL_WORD_FIRST_EN
        crit_valid    = 1'b0;
        crit_data     = '0;
`endif
        case (state_q)
            IDLE: begin
                miss_ready = 1'b1;
                if (miss_valid) begin
                    state_d    = REQ;
                    tag_d      = miss_addr[15:12];
                    index_d    = miss_addr[11:4];
                    word_cnt_d = '0;
                    timer_d    = '0;
`ifdef CRITICAL_WORD_FIRST_EN
                    base_d     = miss_addr[3:2];
`else
                    base_d     = '0;
`endif
                end
            end
            REQ: begin
                mem_req_valid = 1'b1;
                mem_req_addr  = {tag_q, index_q, cur_word, 2'b00};
                if (mem_req_ready) begin
                    state_d = WAIT;
                    timer_d = '0;
                end
            end
            WAIT: begin
                // a response arriving on the timeout cycle still counts
                if (mem_rsp_valid) begin
                    wbuf_d[cur_word] = mem_rsp_data;
                    word_cnt_d       = word_cnt_q + 1'b1;
                    state_d          = (word_cnt_q == 2'd3) ? WRITE : REQ;
`ifdef CRITICAL_WORD_FIRST_EN
                    crit_valid       = (word_cnt_q == 2'd0);
                    crit_data        = (word_cnt_q == 2'd0) ? mem_rsp_data : '0;
`endif
                end else if (timer_q == TIMER_W'(RSP_TIMEOUT)) begin
                    fill_err = 1'b1;
                    state_d  = IDLE;
                end else begin
                    timer_d = timer_q + 1'b1;
                end
            end
            WRITE: begin
                line_we    = 1'b1;
                fill_done  = 1'b1;
                line_index = index_q;
                line_data  = line;
                state_d    = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            tag_q      <= '0;
            index_q    <= '0;
            base_q     <= '0;
            word_cnt_q <= '0;
            timer_q    <= '0;
            for (int i = 0; i < WORDS; i++) wbuf_q[i] <= '0;
        end else begin
            state_q    <= state_d;
            tag_q      <= tag_d;
            index_q    <= index_d;
            base_q     <= base_d;
            word_cnt_q <= word_cnt_d;
            timer_q    <= timer_d;
            for (int i = 0; i < WORDS; i++) wbuf_q[i] <= wbuf_d[i];
        end
    end

endmodule

// File: tb/tb_cache_line_filler.sv
// tb/tb_cache_line_filler.sv - directed self-checking bench for cache_line_filler
module tb_cache_line_filler;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         miss_valid = 1'b0;
    logic         miss_ready;
    logic [15:0]  miss_addr = '0;
    logic         mem_req_valid;
    logic         mem_req_ready = 1'b1;
    logic [15:0]  mem_req_addr;
    logic         mem_rsp_valid = 1'b0;
    logic [31:0]  mem_rsp_data = '0;
    logic         line_we;
    logic [7:0]   line_index;
    logic [132:0] line_data;
    logic         fill_done;
    logic         fill_err;
    logic         busy;
`ifdef CRITICAL_WORD_FIRST_EN
    logic         crit_valid;
    logic [31:0]  crit_data;
`endif

    always #5 clk = ~clk;

    cache_line_filler dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .miss_valid    (miss_valid),
        .miss_ready    (miss_ready),
        .miss_addr     (miss_addr),
        .mem_req_valid (mem_req_valid),
        .mem_req_ready (mem_req_ready),
        .mem_req_addr  (mem_req_addr),
        .mem_rsp_valid (mem_rsp_valid),
        .mem_rsp_data  (mem_rsp_data),
        .line_we       (line_we),
        .line_index    (line_index),
        .line_data     (line_data),
        .fill_done     (fill_done),
        .fill_err      (fill_err),
        .busy          (busy)
`ifdef CRITICAL_WORD_FIRST_EN
        ,
        .crit_valid    (crit_valid),
        .crit_data     (crit_data)
`endif
    );

    int           n_cmp = 0;
    int           n_bad = 0;
    int           cyc = 0;
    int           t0, we_rel, err_rel, we_count, err_count, accepts, stable_bad, done_bad;
    int           crit_count, crit_rel, rsp_given, stall_left;
    int           mute_after = -1;
    logic         hs_pend = 1'b0;
    logic         have_stall = 1'b0;
    logic         after_err = 1'b0;
    logic         ready_after_err;
    logic         junk_in_req = 1'b0;
    logic [15:0]  pend_addr, stall_addr;
    logic [15:0]  req_log [$];
    logic [132:0] we_data;
    logic [7:0]   we_index;
    logic [31:0]  data_base, crit_seen;

    task automatic check_eq(input string tag, input logic [132:0] got, input logic [132:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // sample outputs at negedge, then drive the next cycle's inputs 1ns after posedge
    task automatic tick();
        @(negedge clk);
        if (miss_valid && miss_ready) begin
            accepts++;
            t0 = cyc;
        end
        if (mem_req_valid && mem_req_ready) begin
            if (have_stall && mem_req_addr != stall_addr) stable_bad++;
            have_stall = 1'b0;
            hs_pend    = 1'b1;
            pend_addr  = mem_req_addr;
            req_log.push_back(mem_req_addr);
        end else if (mem_req_valid) begin
            if (have_stall && mem_req_addr != stall_addr) stable_bad++;
            have_stall = 1'b1;
            stall_addr = mem_req_addr;
            if (stall_left > 0) stall_left--;
        end
        if (after_err) begin
            ready_after_err = miss_ready;
            after_err       = 1'b0;
        end
        if (line_we) begin
            we_count++;
            we_rel   = cyc - t0;
            we_data  = line_data;
            we_index = line_index;
            if (!fill_done) done_bad++;
        end else if (fill_done) begin
            done_bad++;
        end
        if (fill_err) begin
            err_count++;
            err_rel   = cyc - t0;
            after_err = 1'b1;
        end
`ifdef CRITICAL_WORD_FIRST_EN
        if (crit_valid) begin
            crit_count++;
            crit_rel  = cyc - t0;
            crit_seen = crit_data;
        end
`endif
        @(posedge clk);
        #1;
        cyc++;
        mem_rsp_valid = 1'b0;
        mem_rsp_data  = '0;
        if (hs_pend) begin
            hs_pend = 1'b0;
            if (mute_after < 0 || rsp_given < mute_after) begin
                mem_rsp_valid = 1'b1;
                mem_rsp_data  = data_base + 32'(pend_addr[3:2]);
                rsp_given++;
            end
        end else if (junk_in_req && mem_req_valid) begin
            mem_rsp_valid = 1'b1;
            mem_rsp_data  = 32'hDEADBEEF;
        end
        mem_req_ready = (stall_left == 0);
    endtask

    task automatic clear_logs();
        req_log.delete();
        we_count = 0; err_count = 0; accepts = 0; stable_bad = 0; done_bad = 0;
        crit_count = 0; rsp_given = 0; we_rel = -1; err_rel = -1; crit_rel = -1;
        we_data = '0; we_index = '0;
    endtask

    task automatic start_miss(input logic [15:0] addr);
        miss_valid = 1'b1;
        miss_addr  = addr;
        tick();
        miss_valid = 1'b0;
        miss_addr  = '0;
    endtask

    task automatic check_fill(input string tag, input logic [15:0] addr, input int lat);
        logic [1:0]   base, w;
        logic [132:0] exp_line;
`ifdef CRITICAL_WORD_FIRST_EN
        base = addr[3:2];
`else
        base = 2'd0;
`endif
        exp_line = {1'b1, addr[15:12], data_base, data_base + 32'd1, data_base + 32'd2, data_base + 32'd3};
        check_eq({tag, "_we_count"}, 133'(we_count), 133'd1);
        check_eq({tag, "_latency"}, 133'(we_rel), 133'(lat));
        check_eq({tag, "_index"}, 133'(we_index), 133'(addr[11:4]));
        check_eq({tag, "_line"}, we_data, exp_line);
        check_eq({tag, "_done_pulse"}, 133'(done_bad), 133'd0);
        check_eq({tag, "_nreq"}, 133'(req_log.size()), 133'd4);
        for (int k = 0; k < 4; k++) begin
            w = base + 2'(k);
            if (k < req_log.size())
                check_eq($sformatf("%s_req%0d", tag, k), 133'(req_log[k]), 133'({addr[15:4], w, 2'b00}));
        end
    endtask

    initial begin
        clear_logs();
        stall_left = 0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_eq("rst_miss_ready", 133'(miss_ready), 133'd1);
        check_eq("rst_busy", 133'(busy), 133'd0);
        check_eq("rst_req_valid", 133'(mem_req_valid), 133'd0);
        check_eq("rst_req_addr", 133'(mem_req_addr), 133'd0);
        check_eq("rst_line_we", 133'(line_we), 133'd0);
        check_eq("rst_line_data", line_data, 133'd0);
        check_eq("rst_fill_err", 133'(fill_err), 133'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        tick();

        // best case: miss 0x3A54, responses one cycle after each request
        clear_logs();
        data_base = 32'hA0;
        start_miss(16'h3A54);
        repeat (12) tick();
        check_fill("basic", 16'h3A54, 9);
        check_eq("basic_line_const", we_data,
                 {1'b1, 4'h3, 32'h000000A0, 32'h000000A1, 32'h000000A2, 32'h000000A3});
        check_eq("basic_no_err", 133'(err_count), 133'd0);

        // three ready-low cycles on first request, junk responses while in REQ
        clear_logs();
        data_base   = 32'h5500_0000;
        stall_left  = 3;
        junk_in_req = 1'b1;
        start_miss(16'h7C1C);
        repeat (15) tick();
        junk_in_req = 1'b0;
        check_fill("stall", 16'h7C1C, 12);
        check_eq("stall_addr_stable", 133'(stable_bad), 133'd0);

        // spurious response in IDLE
        mem_rsp_valid = 1'b1;
        mem_rsp_data  = 32'hBAD0BAD0;
        tick();
        check_eq("idle_rsp_busy", 133'(busy), 133'd0);

        // miss_valid held during a fill is not accepted again
        clear_logs();
        data_base  = 32'h0BAD_0000;
        miss_valid = 1'b1;
        miss_addr  = 16'h4B60;
        repeat (8) tick();
        miss_valid = 1'b0;
        miss_addr  = '0;
        repeat (6) tick();
        check_eq("busy_accepts", 133'(accepts), 133'd1);
        check_fill("hold", 16'h4B60, 9);

        // timeout: only the first request is answered
        clear_logs();
        data_base  = 32'h2000_0000;
        mute_after = 1;
        start_miss(16'h2E40);
        repeat (265) tick();
        mute_after = -1;
        check_eq("to_err_count", 133'(err_count), 133'd1);
        check_eq("to_err_cycle", 133'(err_rel), 133'd259);
        check_eq("to_no_we", 133'(we_count), 133'd0);
        check_eq("to_ready_after", 133'(ready_after_err), 133'd1);
        check_eq("to_nreq", 133'(req_log.size()), 133'd2);

        // reset while waiting for the third fetched word
        clear_logs();
        data_base = 32'h7700_0000;
        start_miss(16'h9F08);
        for (int i = 0; i < 20 && req_log.size() < 3; i++) tick();
        check_eq("rstmid_reached", 133'(req_log.size()), 133'd3);
        rst_n = 1'b0;
        #1;
        check_eq("rstmid_busy", 133'(busy), 133'd0);
        tick();
        rst_n   = 1'b1;
        hs_pend = 1'b0;
        repeat (12) tick();
        check_eq("rstmid_no_we", 133'(we_count), 133'd0);
        check_eq("rstmid_no_err", 133'(err_count), 133'd0);
        clear_logs();
        data_base = 32'h3100_0000;
        start_miss(16'h5A3C);
        repeat (12) tick();
        check_fill("after_rst", 16'h5A3C, 9);

`ifdef CRITICAL_WORD_FIRST_EN
        clear_logs();
        data_base = 32'hC0DE_0000;
        start_miss(16'h1238);
        repeat (12) tick();
        check_fill("cwf", 16'h1238, 9);
        if (req_log.size() == 4) begin
            check_eq("cwf_r0", 133'(req_log[0]), 133'h1238);
            check_eq("cwf_r1", 133'(req_log[1]), 133'h123C);
            check_eq("cwf_r2", 133'(req_log[2]), 133'h1230);
            check_eq("cwf_r3", 133'(req_log[3]), 133'h1234);
        end
        check_eq("cwf_crit_count", 133'(crit_count), 133'd1);
        check_eq("cwf_crit_cycle", 133'(crit_rel), 133'd2);
        check_eq("cwf_crit_data", 133'(crit_seen), 133'hC0DE_0002);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
